// File: rtl/store_outstanding_tracker_pkg.sv
// Shared configuration, tracker state encoding and the non-idempotent region lookup
// used by the store tracker and the PMA checker.
package store_outstanding_tracker_pkg;

    localparam int unsigned MaxRules  = 4;
    localparam int unsigned RuleIdxW  = 2;

    typedef struct packed {
        int unsigned               MaxOutstandingStores;
        int unsigned               NrNonIdempotentRules;
        logic [MaxRules-1:0][63:0] NonIdempotentAddrBase;
        logic [MaxRules-1:0][63:0] NonIdempotentLength;
    } cva6_cfg_t;

    localparam cva6_cfg_t DefaultCfg = '{
        MaxOutstandingStores:  7,
        NrNonIdempotentRules:  1,
        NonIdempotentAddrBase: {64'h0, 64'h0, 64'h0, 64'h0000_0000_1000_0000},
        NonIdempotentLength:   {64'h0, 64'h0, 64'h0, 64'h0000_0000_0000_1000}
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } tracker_state_e;

    // Offset compare (addr - base < length) avoids overflow of base + length near the top of memory.
    function automatic logic is_inside_nonidempotent_regions(input cva6_cfg_t cfg,
                                                             input logic [63:0] addr);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < MaxRules; i++) begin
            if ((i < cfg.NrNonIdempotentRules) &&
                (cfg.NonIdempotentLength[i[RuleIdxW-1:0]] != 64'd0) &&
                (addr >= cfg.NonIdempotentAddrBase[i[RuleIdxW-1:0]]) &&
                ((addr - cfg.NonIdempotentAddrBase[i[RuleIdxW-1:0]]) <
                 cfg.NonIdempotentLength[i[RuleIdxW-1:0]])) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/store_outstanding_tracker_nonidem_region_match.sv
// Combinational non-idempotent region lookup for one address path.
module nonidem_region_match
    import store_outstanding_tracker_pkg::*;
#(
    parameter cva6_cfg_t CVA6Cfg = DefaultCfg
) (
    input  logic [63:0] addr,
    output logic        match
);

    assign match = is_inside_nonidempotent_regions(CVA6Cfg, addr);

endmodule

// File: rtl/store_outstanding_tracker.sv
// Tracks issued-but-unacknowledged stores, gates loads/stores to non-idempotent
// regions behind in-flight stores, and sequences fence drains.
module store_outstanding_tracker
    import store_outstanding_tracker_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg  = DefaultCfg,
    parameter int unsigned CntWidth = $clog2(CVA6Cfg.MaxOutstandingStores + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                st_req_i,
    input  logic [63:0]         st_addr_i,
    output logic                st_gnt_o,
    input  logic                st_ack_i,
    input  logic                ld_req_i,
    input  logic [63:0]         ld_addr_i,
    output logic                ld_gnt_o,
    input  logic                fence_i,
    output logic                fence_done_o,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                empty_o,
    output logic                err_o
);

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(CVA6Cfg.MaxOutstandingStores);

    tracker_state_e      state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                st_nonidem, ld_nonidem;
    logic                cnt_zero, grant_en, st_issue;

    nonidem_region_match #(.CVA6Cfg(CVA6Cfg)) u_st_match (
        .addr  (st_addr_i),
        .match (st_nonidem)
    );

    nonidem_region_match #(.CVA6Cfg(CVA6Cfg)) u_ld_match (
        .addr  (ld_addr_i),
        .match (ld_nonidem)
    );

    assign cnt_zero = (cnt_q == '0);
    assign st_gnt_o = grant_en && (cnt_q < MaxCnt) && (!st_nonidem || cnt_zero);
    assign ld_gnt_o = grant_en && (!ld_nonidem || cnt_zero);
    assign st_issue = st_req_i && st_gnt_o;

    // An ack with nothing outstanding is a protocol error; the count is left at zero.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (st_issue && !st_ack_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!st_issue && st_ack_i) begin
            if (cnt_zero) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_en     = 1'b0;
        fence_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                grant_en = 1'b1;
                if (fence_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_zero) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                fence_done_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign empty_o       = cnt_zero;
    assign err_o         = err_q;

    // A load by itself never moves the store count.
    ld_keeps_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (ld_req_i && !st_issue && !st_ack_i) |=> (cnt_q == $past(cnt_q)));

endmodule

// File: tb/tb_store_outstanding_tracker.sv
// Directed scoreboard bench: stimulus queues hand-computed expected outputs per cycle,
// a monitor compares them against the DUT on the falling edge.
module tb_store_outstanding_tracker;
    import store_outstanding_tracker_pkg::*;

    localparam logic [63:0] ID_ADDR   = 64'h0000_0000_8000_0000;
    localparam logic [63:0] NI_ADDR   = 64'h0000_0000_1000_0010;
    localparam logic [63:0] NI_BASE   = 64'h0000_0000_1000_0000;
    localparam logic [63:0] BELOW     = 64'h0000_0000_0FFF_FFFF;
    localparam logic [63:0] PAST_ADDR = 64'h0000_0000_1000_1000;

    logic        clk;
    logic        rst_n;
    logic        st_req;
    logic [63:0] st_addr;
    logic        st_gnt;
    logic        st_ack;
    logic        ld_req;
    logic [63:0] ld_addr;
    logic        ld_gnt;
    logic        fence;
    logic        fence_done;
    logic [2:0]  outstanding;
    logic        empty;
    logic        err;

    typedef struct {
        int         cyc;
        string      name;
        logic [2:0] cnt;
        logic       sg;
        logic       lg;
        logic       fd;
        logic       er;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    store_outstanding_tracker #(.CVA6Cfg(DefaultCfg)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .st_req_i      (st_req),
        .st_addr_i     (st_addr),
        .st_gnt_o      (st_gnt),
        .st_ack_i      (st_ack),
        .ld_req_i      (ld_req),
        .ld_addr_i     (ld_addr),
        .ld_gnt_o      (ld_gnt),
        .fence_i       (fence),
        .fence_done_o  (fence_done),
        .outstanding_o (outstanding),
        .empty_o       (empty),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL %s: expectation for cycle %0d reached only at cycle %0d",
                         e.name, e.cyc, cyc);
            end else if ({outstanding, empty, st_gnt, ld_gnt, fence_done, err} !==
                         {e.cnt, (e.cnt == 3'd0), e.sg, e.lg, e.fd, e.er}) begin
                failures++;
                $display("FAIL %s @%0d: got cnt=%0d empty=%b st_gnt=%b ld_gnt=%b done=%b err=%b, want cnt=%0d empty=%b st_gnt=%b ld_gnt=%b done=%b err=%b",
                         e.name, cyc, outstanding, empty, st_gnt, ld_gnt, fence_done, err,
                         e.cnt, (e.cnt == 3'd0), e.sg, e.lg, e.fd, e.er);
            end
        end
    end

    task automatic set_in(input logic sr, input logic [63:0] sa, input logic sk,
                          input logic lr, input logic [63:0] la, input logic fe);
        st_req  = sr;
        st_addr = sa;
        st_ack  = sk;
        ld_req  = lr;
        ld_addr = la;
        fence   = fe;
    endtask

    task automatic chk(input string nm, input logic [2:0] c, input logic sg,
                       input logic lg, input logic fd, input logic er);
        q.push_back('{cyc: cyc, name: nm, cnt: c, sg: sg, lg: lg, fd: fd, er: er});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_in(0, ID_ADDR, 0, 0, ID_ADDR, 0);
        tick;
        chk("reset", 0, 1, 1, 0, 0);
        tick;
        rst_n = 1'b1;
        chk("reset_release", 0, 1, 1, 0, 0);
        tick;

        // Fill to the cap, then one ack reopens the store grant.
        for (int k = 0; k < 7; k++) begin
            set_in(1, ID_ADDR, 0, 0, ID_ADDR, 0);
            chk("fill", 3'(k), 1, 1, 0, 0);
            tick;
        end
        set_in(1, ID_ADDR, 0, 0, ID_ADDR, 0);
        chk("full_no_grant", 7, 0, 1, 0, 0);
        tick;
        set_in(0, ID_ADDR, 1, 0, ID_ADDR, 0);
        chk("full_ack", 7, 0, 1, 0, 0);
        tick;
        set_in(0, ID_ADDR, 0, 0, ID_ADDR, 0);
        chk("after_ack", 6, 1, 1, 0, 0);
        tick;
        for (int j = 0; j < 3; j++) begin
            set_in(0, ID_ADDR, 1, 0, ID_ADDR, 0);
            chk("ack_down", 3'(6 - j), 1, 1, 0, 0);
            tick;
        end

        // Issue and ack in the same cycle leave the count alone.
        set_in(1, ID_ADDR, 1, 0, ID_ADDR, 0);
        chk("issue_ack_same", 3, 1, 1, 0, 0);
        tick;
        set_in(0, ID_ADDR, 1, 0, ID_ADDR, 0);
        chk("issue_ack_hold", 3, 1, 1, 0, 0);
        tick;

        // Region gating with two stores in flight.
        set_in(0, NI_ADDR, 0, 1, NI_ADDR, 0);
        chk("nonidem_blocked", 2, 0, 0, 0, 0);
        tick;
        set_in(0, PAST_ADDR, 0, 1, PAST_ADDR, 0);
        chk("past_region", 2, 1, 1, 0, 0);
        tick;
        set_in(0, NI_BASE, 0, 1, BELOW, 0);
        chk("region_edges", 2, 0, 1, 0, 0);
        tick;
        set_in(0, NI_ADDR, 1, 1, NI_ADDR, 0);
        chk("nonidem_ack1", 2, 0, 0, 0, 0);
        tick;
        set_in(0, NI_ADDR, 1, 1, NI_ADDR, 0);
        chk("nonidem_ack2", 1, 0, 0, 0, 0);
        tick;
        set_in(0, NI_ADDR, 0, 1, NI_ADDR, 0);
        chk("nonidem_free", 0, 1, 1, 0, 0);
        tick;

        // Fence with two stores draining, acks at +3 and +5.
        set_in(1, ID_ADDR, 0, 0, ID_ADDR, 0);
        chk("pre_fill0", 0, 1, 1, 0, 0);
        tick;
        chk("pre_fill1", 1, 1, 1, 0, 0);
        tick;
        set_in(0, ID_ADDR, 0, 0, ID_ADDR, 1);
        chk("fence_issue", 2, 1, 1, 0, 0);
        tick;
        set_in(0, ID_ADDR, 0, 0, ID_ADDR, 0);
        chk("drain1", 2, 0, 0, 0, 0);
        tick;
        chk("drain2", 2, 0, 0, 0, 0);
        tick;
        set_in(0, ID_ADDR, 1, 0, ID_ADDR, 0);
        chk("drain3_ack", 2, 0, 0, 0, 0);
        tick;
        set_in(0, ID_ADDR, 0, 0, ID_ADDR, 0);
        chk("drain4", 1, 0, 0, 0, 0);
        tick;
        set_in(0, ID_ADDR, 1, 0, ID_ADDR, 0);
        chk("drain5_ack", 1, 0, 0, 0, 0);
        tick;
        set_in(0, ID_ADDR, 0, 0, ID_ADDR, 0);
        chk("drain6_zero", 0, 0, 0, 0, 0);
        tick;
        chk("fence_done", 0, 0, 0, 1, 0);
        tick;
        chk("fence_idle", 0, 1, 1, 0, 0);
        tick;

        // Fence at zero count; a second fence while draining is ignored.
        set_in(0, ID_ADDR, 0, 0, ID_ADDR, 1);
        chk("fence0_issue", 0, 1, 1, 0, 0);
        tick;
        chk("fence0_drain", 0, 0, 0, 0, 0);
        tick;
        set_in(0, ID_ADDR, 0, 0, ID_ADDR, 0);
        chk("fence0_done", 0, 0, 0, 1, 0);
        tick;
        chk("fence0_idle", 0, 1, 1, 0, 0);
        tick;

        // A store issued alongside the fence is counted before the drain completes.
        set_in(1, ID_ADDR, 0, 0, ID_ADDR, 1);
        chk("fence_store", 0, 1, 1, 0, 0);
        tick;
        set_in(1, ID_ADDR, 0, 0, ID_ADDR, 0);
        chk("fence_store_drain", 1, 0, 0, 0, 0);
        tick;
        set_in(0, ID_ADDR, 1, 0, ID_ADDR, 0);
        chk("fence_store_ack", 1, 0, 0, 0, 0);
        tick;
        set_in(0, ID_ADDR, 0, 0, ID_ADDR, 0);
        chk("fence_store_zero", 0, 0, 0, 0, 0);
        tick;
        chk("fence_store_done", 0, 0, 0, 1, 0);
        tick;

        // Sticky error on an unmatched ack, cleared only by reset.
        rst_n = 1'b0;
        chk("rst_idle", 0, 1, 1, 0, 0);
        tick;
        rst_n = 1'b1;
        set_in(0, ID_ADDR, 1, 0, ID_ADDR, 0);
        chk("ack_at_zero", 0, 1, 1, 0, 0);
        tick;
        set_in(1, ID_ADDR, 0, 0, ID_ADDR, 0);
        chk("err_set", 0, 1, 1, 0, 1);
        tick;
        set_in(0, ID_ADDR, 1, 0, ID_ADDR, 0);
        chk("err_hold1", 1, 1, 1, 0, 1);
        tick;
        set_in(0, ID_ADDR, 0, 0, ID_ADDR, 0);
        chk("err_hold2", 0, 1, 1, 0, 1);
        tick;
        rst_n = 1'b0;
        chk("err_clear", 0, 1, 1, 0, 0);
        tick;
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a drain with four stores pending.
        for (int k = 0; k < 4; k++) begin
            set_in(1, ID_ADDR, 0, 0, ID_ADDR, 0);
            chk("fill4", 3'(k), 1, 1, 0, 0);
            tick;
        end
        set_in(0, ID_ADDR, 0, 0, ID_ADDR, 1);
        chk("fence4", 4, 1, 1, 0, 0);
        tick;
        set_in(0, ID_ADDR, 0, 0, ID_ADDR, 0);
        chk("drain_cnt4", 4, 0, 0, 0, 0);
        tick;
        #2;
        rst_n = 1'b0;
        chk("mid_drain_reset", 0, 1, 1, 0, 0);
        tick;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("post_reset", 0, 1, 1, 0, 0);
            tick;
        end
        set_in(1, ID_ADDR, 0, 0, ID_ADDR, 0);
        chk("post_reset_issue", 0, 1, 1, 0, 0);
        tick;
        set_in(0, ID_ADDR, 0, 0, ID_ADDR, 0);
        chk("post_reset_count", 1, 1, 1, 0, 0);
        tick;

        repeat (3) tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
